// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants and buffer-entry type for the RF write arbiter
// Revision    : 1.0
// ============================================================================
package rf_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic          live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wbuf_entry_t;
endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : WB / MDU / register-file / decode signals of the write arbiter
// Revision    : 1.0
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          mdu_valid;
    logic [AW-1:0] mdu_waddr;
    logic [DW-1:0] mdu_wdata;
    logic          mdu_ready;
    logic          rf_regwrite;
    logic [AW-1:0] rf_writereg;
    logic [DW-1:0] rf_writeda;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          stall;
    logic [CW-1:0] count;

    modport slave (
        input  wb_we, wb_waddr, wb_wdata,
        input  mdu_valid, mdu_waddr, mdu_wdata,
        input  rd_addr1, rd_addr2,
        output mdu_ready, rf_regwrite, rf_writereg, rf_writeda, stall, count
    );

    modport master (
        output wb_we, wb_waddr, wb_wdata,
        output mdu_valid, mdu_waddr, mdu_wdata,
        output rd_addr1, rd_addr2,
        input  mdu_ready, rf_regwrite, rf_writereg, rf_writeda, stall, count
    );
endinterface
`default_nettype wire

// File: rtl/rf_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : rf_wbuf
// Description : In-order MDU result FIFO with per-entry live flag and kill port
// Revision    : 1.0
// ============================================================================
module rf_wbuf #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       push_live,
    input  wire logic [AW-1:0]              push_addr,
    input  wire logic [DW-1:0]              push_data,
    input  wire logic                       pop,
    input  wire logic                       kill,
    input  wire logic [AW-1:0]              kill_addr,
    output logic                            head_live,
    output logic [AW-1:0]                   head_addr,
    output logic [DW-1:0]                   head_data,
    output logic [$clog2(DEPTH):0]          count,
    output logic [DEPTH-1:0]                ent_live,
    output logic [AW-1:0]                   ent_addr [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    // Later assignments win: kill, then pop clears the vacated slot, then push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_live  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && (r_addr[i] == kill_addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                r_live[r_head] <= 1'b0;
                r_head         <= r_head + 1'b1;
            end
            if (push) begin
                r_live[r_tail] <= push_live;
                r_tail         <= r_tail + 1'b1;
            end
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_addr[r_tail] <= push_addr;
            r_data[r_tail] <= push_data;
        end
    end

    assign head_live = r_live[r_head];
    assign head_addr = r_addr[r_head];
    assign head_data = r_data[r_head];
    assign count     = r_count;
    assign ent_live  = r_live;
    assign ent_addr  = r_addr;
endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the RF write port between writeback and the MDU buffer
// Revision    : 1.0
// ============================================================================
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = rf_pkg::AW,
    parameter int DW    = rf_pkg::DW
) (
    input wire logic          clk,
    input wire logic          rst,
    rf_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_wb_eff;
    logic          w_ready;
    logic          w_push;
    logic          w_push_live;
    logic          w_pop;
    logic          w_head_valid;
    logic          w_head_live;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic [CW-1:0] w_count;
    logic [DEPTH-1:0] w_ent_live;
    logic [AW-1:0] w_ent_addr [DEPTH];
    logic          w_stall;

    logic          r_regwrite;
    logic [AW-1:0] r_writereg;
    logic [DW-1:0] r_writeda;

    function automatic logic src_hit(input logic [AW-1:0] src, input logic [AW-1:0] dst);
        return (src != AW'(REG_ZERO)) && (src == dst);
    endfunction

    assign w_wb_eff     = bus.wb_we && (bus.wb_waddr != AW'(REG_ZERO));
    assign w_ready      = !rst && (w_count < CW'(DEPTH));
    assign w_push       = bus.mdu_valid && w_ready;
    // WB is younger than a same-cycle MDU result to the same register.
    assign w_push_live  = (bus.mdu_waddr != AW'(REG_ZERO)) &&
                          !(w_wb_eff && (bus.wb_waddr == bus.mdu_waddr));
    assign w_head_valid = (w_count != '0);
    assign w_pop        = w_head_valid && (!w_head_live || !w_wb_eff);

    rf_wbuf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_live (w_push_live),
        .push_addr (bus.mdu_waddr),
        .push_data (bus.mdu_wdata),
        .pop       (w_pop),
        .kill      (w_wb_eff),
        .kill_addr (bus.wb_waddr),
        .head_live (w_head_live),
        .head_addr (w_head_addr),
        .head_data (w_head_data),
        .count     (w_count),
        .ent_live  (w_ent_live),
        .ent_addr  (w_ent_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite <= 1'b0;
            r_writereg <= '0;
            r_writeda  <= '0;
        end else if (w_wb_eff) begin
            r_regwrite <= 1'b1;
            r_writereg <= bus.wb_waddr;
            r_writeda  <= bus.wb_wdata;
        end else if (w_head_valid && w_head_live) begin
            r_regwrite <= 1'b1;
            r_writereg <= w_head_addr;
            r_writeda  <= w_head_data;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    always_comb begin
        w_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_live[i] && (src_hit(bus.rd_addr1, w_ent_addr[i]) ||
                                  src_hit(bus.rd_addr2, w_ent_addr[i]))) begin
                w_stall = 1'b1;
            end
        end
        if (w_push && (src_hit(bus.rd_addr1, bus.mdu_waddr) ||
                       src_hit(bus.rd_addr2, bus.mdu_waddr))) begin
            w_stall = 1'b1;
        end
    end

    assign bus.mdu_ready   = w_ready;
    assign bus.rf_regwrite = r_regwrite;
    assign bus.rf_writereg = r_writereg;
    assign bus.rf_writeda  = r_writeda;
    assign bus.stall       = w_stall;
    assign bus.count       = w_count;
endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Randomized bench with a queue-based reference model
// Revision    : 1.0
// ============================================================================
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();

    rf_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    wbuf_entry_t   q[$];
    logic          e_ready, e_stall, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit            chk_en   = 1'b0;
    bit            last_acc = 1'b0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic bit hit(input logic [AW-1:0] src, input logic [AW-1:0] dst);
        return (src != 0) && (src == dst);
    endfunction

    // Drive one cycle of inputs at the falling edge, then advance the model.
    task automatic step(input bit r, input bit we, input int wa, input int wd,
                        input bit mv, input int ma, input int md, input int a1, input int a2);
        bit wbe, acc, pop;
        logic [AW-1:0] wav, mav, a1v, a2v;
        @(negedge clk);
        wav = AW'(wa); mav = AW'(ma); a1v = AW'(a1); a2v = AW'(a2);
        rst           = r;
        bus.wb_we     = we;
        bus.wb_waddr  = wav;
        bus.wb_wdata  = DW'(wd);
        bus.mdu_valid = mv;
        bus.mdu_waddr = mav;
        bus.mdu_wdata = DW'(md);
        bus.rd_addr1  = a1v;
        bus.rd_addr2  = a2v;
        #1;
        wbe     = we && (wav != 0);
        e_ready = !r && (q.size() < DEPTH);
        acc     = mv && e_ready;
        e_stall = 1'b0;
        foreach (q[i])
            if (q[i].live && (hit(a1v, q[i].addr) || hit(a2v, q[i].addr))) e_stall = 1'b1;
        if (acc && (hit(a1v, mav) || hit(a2v, mav))) e_stall = 1'b1;
        last_acc = acc;
        if (r) begin
            q.delete();
            e_we = 1'b0; e_addr = '0; e_data = '0;
        end else begin
            if (wbe) begin
                e_we = 1'b1; e_addr = wav; e_data = DW'(wd);
            end else if (q.size() > 0 && q[0].live) begin
                e_we = 1'b1; e_addr = q[0].addr; e_data = q[0].data;
            end else begin
                e_we = 1'b0;
            end
            pop = (q.size() > 0) && (!q[0].live || !wbe);
            if (wbe) foreach (q[i]) if (q[i].addr == wav) q[i].live = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{live: (mav != 0) && !(wbe && mav == wav), addr: mav, data: DW'(md)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Compare process: combinational outputs mid-low-phase, registered ones after the edge.
    always begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            chk("mdu_ready", bus.mdu_ready, e_ready);
            chk("stall", bus.stall, e_stall);
        end
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("rf_regwrite", bus.rf_regwrite, e_we);
            if (e_we) begin
                chk("rf_writereg", bus.rf_writereg, e_addr);
                chk("rf_writeda", bus.rf_writeda, e_data);
            end
            chk("count", bus.count, q.size());
        end
    end

    bit hv;
    int ha, hd;

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("reset_writereg", bus.rf_writereg, 0);
        chk("reset_writeda", bus.rf_writeda, 0);

        // Reset mid-drain
        step(0, 1, 1, 'h10, 1, 10, 'h11, 0, 0);
        step(0, 1, 1, 'h10, 1, 11, 'h22, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("rstmid_count", bus.count, 0);
        chk("rstmid_regwrite", bus.rf_regwrite, 0);
        idle(3);

        // WB only
        step(0, 1, 5, 8, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("wb_regwrite", bus.rf_regwrite, 1);
        chk("wb_writereg", bus.rf_writereg, 5);
        chk("wb_writeda", bus.rf_writeda, 8);
        step(0, 1, 0, 8, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("wb0_regwrite", bus.rf_regwrite, 0);

        // Contention
        step(0, 1, 2, 1, 1, 7, 'h63, 7, 0);
        #2; chk("cont_stall0", bus.stall, 1);
        step(0, 1, 2, 2, 0, 0, 0, 7, 0);
        #2; chk("cont_stall1", bus.stall, 1);
        step(0, 1, 2, 3, 0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 7, 0);
        #2; chk("cont_stall3", bus.stall, 1);
        @(posedge clk); #2;
        chk("cont_writereg", bus.rf_writereg, 7);
        chk("cont_writeda", bus.rf_writeda, 'h63);
        step(0, 0, 0, 0, 0, 0, 0, 7, 0);
        #2; chk("cont_stall_drop", bus.stall, 0);

        // Full buffer
        step(0, 1, 1, 0, 1, 12, 'hC, 0, 0);
        step(0, 1, 1, 0, 1, 13, 'hD, 0, 0);
        step(0, 1, 1, 0, 1, 14, 'hE, 0, 0);
        #2;
        chk("full_ready", bus.mdu_ready, 0);
        chk("full_count", bus.count, 2);
        step(0, 0, 0, 0, 1, 14, 'hE, 0, 0);
        step(0, 0, 0, 0, 1, 14, 'hE, 0, 0);
        #2; chk("full_ready_again", bus.mdu_ready, 1);
        idle(4);

        // Ordering kill
        step(0, 1, 1, 0, 1, 9, 'hAA, 0, 0);
        step(0, 1, 9, 'hBB, 0, 0, 0, 9, 0);
        #2; chk("kill_stall", bus.stall, 1);
        @(posedge clk); #2;
        chk("kill_writereg", bus.rf_writereg, 9);
        chk("kill_writeda", bus.rf_writeda, 'hBB);
        step(0, 0, 0, 0, 0, 0, 0, 9, 0);
        #2; chk("kill_stall_drop", bus.stall, 0);
        @(posedge clk); #2;
        chk("kill_nowrite", bus.rf_regwrite, 0);
        idle(2);

        // Same-cycle push, kill and pop
        step(0, 1, 1, 0, 1, 4, 5, 0, 0);
        step(0, 1, 3, 1, 1, 3, 2, 0, 0);
        @(posedge clk); #2;
        chk("same_reg3", bus.rf_writereg, 3);
        chk("same_data3", bus.rf_writeda, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("same_reg4", bus.rf_writereg, 4);
        chk("same_data4", bus.rf_writeda, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        chk("same_dead", bus.rf_regwrite, 0);

        // Randomized traffic; a pending MDU result is held until accepted
        hv = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 9) < 4);
                ha = $urandom_range(0, 7);
                hd = $urandom;
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
                 $urandom, hv, ha, hd, $urandom_range(0, 7), $urandom_range(0, 7));
            if (last_acc) hv = 1'b0;
        end
        idle(4);
        chk_en = 1'b0;
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (`regwrite`/`writereg`/`writeda`, committed on the falling clock edge) between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Writeback always wins. MDU results wait in a small in-order buffer and drain into idle write slots. The block also drives a decode-stage stall for any source register with a buffered MDU write still pending. It sits between WB/MDU and `Registers`; its registered outputs feed the register file's write port directly.

## Interface
- `DEPTH`, 2: MDU result buffer entries (power of two, ≥2)
- `AW`, 5: register address width
- `DW`, 32: data width
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `wb_we`  in  1  writeback write request
- `wb_waddr`  in  AW  writeback destination
- `wb_wdata`  in  DW  writeback data
- `mdu_valid`  in  1  MDU result available
- `mdu_waddr`  in  AW  MDU destination
- `mdu_wdata`  in  DW  MDU data
- `mdu_ready`  out  1  buffer can accept (`count < DEPTH`)
- `rf_regwrite`  out  1  to register file `regwrite`
- `rf_writereg`  out  AW  to `writereg`
- `rf_writeda`  out  DW  to `writeda`
- `rd_addr1`, `rd_addr2`  in  AW  decode-stage source registers
- `stall`  out  1  source has a pending MDU write
- `count`  out  $clog2(DEPTH)+1  occupied buffer entries

## Operation
- Effective WB write: `wb_we && wb_waddr != 0`. Writes to `$0` are never issued, from either source.
- MDU handshake: the result is accepted when `mdu_valid && mdu_ready`. It is pushed to the buffer tail with `live=1`. A push with `mdu_waddr == 0` is stored with `live=0`.
- Slot selection each cycle:
  1. Effective WB write: the WB write is registered to the `rf_*` outputs.
  2. Otherwise, if the head is live, it is popped and registered to the outputs.
  3. Otherwise, `rf_regwrite` is registered as 0.
- Dead entries: a non-live head is popped in any cycle, including WB cycles, with no write issued. At most one pop per cycle.
- Ordering kill: an effective WB write to address A clears `live` on every buffered entry with address A. It also clears `live` on an entry being pushed that cycle with address A, because WB is younger in program order.
- Push and pop in the same cycle: allowed. `count` is unchanged. Entries stay in order.
- Full: `mdu_ready=0`, and the MDU holds its result. No push occurs while full, even if a pop happens that cycle (`ready` is computed from the current `count`).
- Stall (combinational): `stall=1` if `rd_addrN != 0` matches the address of any live buffered entry, or of an MDU result being accepted this cycle, for N=1 or 2.
- Reset: `rf_regwrite=0`, `rf_writereg=0`, `rf_writeda=0`, `count=0`, all entries non-live, `mdu_ready=0` while `rst=1`. An in-flight buffered result is discarded by reset.

## Timing
- WB request in cycle t: `rf_*` outputs valid from edge t+1. The register file commits at the falling edge in cycle t+1.
- MDU result: minimum latency is 2 edges (push at t+1, drained onto outputs at t+2) when WB is idle.
- Starvation: continuous WB writes hold a live head indefinitely. This is acceptable; the pipeline is responsible for inserting bubbles.
- `stall` deasserts the cycle after the head entry's write reaches the outputs. The falling-edge commit makes the value readable in that same cycle.

## Structure
- Shared package `rf_pkg`: `REG_ZERO = 5'd0`, `AW`/`DW` defaults, and a struct/typedef for a buffer entry {`live`, `addr`, `data`}.
- One sub-module, `rf_wbuf`: DEPTH-entry circular FIFO with head/tail pointers, a per-entry `live` flag, an address-match kill port, and per-entry address/live taps for the stall compare.
- The top level holds slot selection, the output registers and the stall logic.

## Test plan
- Reset mid-drain: push 2 MDU results, assert `rst` for 1 cycle → `count=0`, `rf_regwrite=0`, and no write of those values ever appears.
- WB only: `wb_we=1`, addr 5, data 8 at t → at t+1, `rf_regwrite=1`, `rf_writereg=5`, `rf_writeda=8`. With addr 0 → `rf_regwrite=0`.
- Contention: WB writes addr 2 for 3 cycles while MDU pushes (7, 0x63) → the MDU write appears only in the first idle cycle after WB stops. `stall=1` with `rd_addr1=7` until then.
- Full buffer: 3 back-to-back MDU results with WB busy → `mdu_ready=0` after 2 pushes, `count=2`, and the third result is accepted only after a pop.
- Ordering kill: MDU pushes (9, 0xAA), then WB writes (9, 0xBB) before the drain → only 0xBB is written to reg 9. The dead entry is popped without a write and `stall` on 9 drops.
- Same-cycle push, kill and pop: WB (3, 1), MDU push (3, 2) with a live head (4, 5) present → order of writes is reg3=1, then reg4=5. Reg3 is never overwritten with 2.
